pwm_deadtime_driver: RTL and testbench
======================================

// Module: pwm_deadtime_driver
// PURPOSE
//   Output stage of the PWM path. Consumes the period-start pulse, which also triggers the timer, and the timer's duty-end pulse.
//   Drives a complementary high/low gate pair with programmable dead time. Guarantees pwm_h and pwm_l are never high together.
//   Flags periods where the duty-end pulse never arrived.
// PARAMETERS
//   DT_W   4   width of dead_time input and of the internal dead-time counter
// PORTS
//   clk            in   1     system clock, rising edge
//   rst            in   1     synchronous, active-high reset
//   enable         in   1     1 = run; 0 = force both outputs low (state OFF)
//   period_start   in   1     1-cycle pulse at each PWM period boundary
//   duty_end       in   1     1-cycle pulse from timer out_pulse (end of high phase)
//   dead_time      in   DT_W  dead time in clk cycles; sampled on entry to a DT state
//   pwm_h          out  1     high-side drive, registered
//   pwm_l          out  1     low-side drive, registered
//   active         out  1     registered; 1 when state != OFF
//   miss_pulse     out  1     registered 1-cycle pulse: period_start seen while in ON_H
// BEHAVIOUR
// - Clock and reset: one clock; reset is synchronous and active-high.
// - Reset values: state = OFF; pwm_h = pwm_l = active = miss_pulse = 0; dt_cnt = 0.
// - Outputs: all are registered, decoded from next state. pwm_h = (ON_H), pwm_l = (ON_L).
// - States: OFF, DT_RISE, ON_H, DT_FALL, ON_L.
// - Priority at each edge: rst > !enable > period_start > duty_end.
//   - !enable from any state -> OFF. Both outputs read 0 in the next cycle.
// - OFF:
//   - period_start & enable -> DT_RISE with dt_cnt = dead_time.
//   - If dead_time == 0, go straight to ON_H.
// - DT_RISE:
//   - dt_cnt decrements each cycle; at dt_cnt == 1 -> ON_H.
//   - With period_start at edge k and D = dead_time, pwm_h is 1 from cycle k+D+1 (after edge k+D).
//   - pwm_l is 0 from cycle k+1 (after edge k).
//   - period_start: ignored, no reload.
//   - duty_end: abort to DT_FALL with full dead_time reload. This is the short/zero-duty case; pwm_h never rises.
// - ON_H:
//   - duty_end -> DT_FALL (reload dead_time; D == 0 goes straight to ON_L). pwm_h is 0 in the next cycle.
//   - period_start -> stay ON_H (100% duty) and fire miss_pulse for 1 cycle. This also applies when duty_end arrives in the same cycle, since period_start wins.
// - DT_FALL:
//   - Counts as DT_RISE; at dt_cnt == 1 -> ON_L.
//   - period_start -> DT_RISE, reloading dead_time.
// - ON_L:
//   - period_start -> DT_RISE (or ON_H if dead_time == 0).
//   - duty_end: ignored.
// - Dead time: dead_time is captured only on DT-state entry; changes mid-count have no effect until the next entry.
//   - Max dead_time 2^DT_W-1; no wrap, because the counter stops at the transition.
// - Invariants:
//   - Whenever dead_time != 0, pwm_h & pwm_l is always 0.
//   - An h<->l swap always includes at least dead_time cycles with both outputs low.
// - Reset mid-operation: next edge returns to OFF with reset values. Any in-flight dead-time count is discarded.
// STRUCTURE
// - Shared package pwm_pkg:
//   - typedef enum for the 5 states above.
//   - localparam DT_W_DEF = 4.
// - Sub-module deadtime_counter:
//   - Ports: clk, rst, load, load_val[DT_W], done.
//   - done is asserted while cnt == 1, or the same cycle as load when load_val == 0.
//   - Used for both DT_RISE and DT_FALL.
// TESTING
// 1. rst for 2 cycles, enable=1, dead_time=3, period_start at cycle 10, duty_end at cycle 20.
//    -> pwm_l=0 from cycle 11; pwm_h=1 over cycles 14..20; pwm_l=1 from cycle 24.
// 2. dead_time=0, period_start @5, duty_end @9 -> pwm_h=1 over cycles 6..9; pwm_l=1 from cycle 10; never both high.
// 3. In ON_H, period_start with no duty_end -> pwm_h stays 1; miss_pulse=1 for exactly 1 cycle.
//    Repeat with period_start and duty_end in the same cycle -> same result.
// 4. dead_time=5, duty_end arrives 2 cycles into DT_RISE -> pwm_h never rises; pwm_l rises 5 cycles after duty_end.
// 5. Drop enable in ON_H -> next cycle pwm_h=pwm_l=active=0.
//    Assert rst mid-DT_FALL -> next cycle all outputs 0, state OFF.
// 6. Change dead_time from 2 to 7 mid-DT_RISE -> current gap is still 2 cycles; next entry uses 7.
//    Run 1000 random cycles with assertion !(pwm_h & pwm_l).

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM output stage.
package pwm_pkg;

  localparam int DT_W_DEF = 4;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_DT_RISE,
    ST_ON_H,
    ST_DT_FALL,
    ST_ON_L
  } state_t;

endpackage

// File: rtl/pwm_deadtime_driver_deadtime_counter.sv
// Down-counter that times one dead-time gap; shared by the rising and falling gaps.
module deadtime_counter
  import pwm_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [DT_W-1:0] load_val,
  output logic            done
);

  logic [DT_W-1:0] dt_cnt;

  // Stops at zero, so the maximum load value never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      dt_cnt <= '0;
    end else if (load) begin
      dt_cnt <= load_val;
    end else if (dt_cnt != '0) begin
      dt_cnt <= dt_cnt - DT_W'(1);
    end
  end

  // A load supersedes any count in flight; a zero load finishes immediately.
  assign done = load ? (load_val == '0) : (dt_cnt == DT_W'(1));

endmodule

// File: rtl/pwm_deadtime_driver.sv
// Complementary gate driver with programmable dead time and missed-duty-end detection.
module pwm_deadtime_driver
  import pwm_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            period_start,
  input  logic            duty_end,
  input  logic [DT_W-1:0] dead_time,
  output logic            pwm_h,
  output logic            pwm_l,
  output logic            active,
  output logic            miss_pulse
);

  state_t state_reg;
  state_t state_next;
  logic   load_rise;
  logic   load_fall;
  logic   dt_load;
  logic   dt_done;
  logic   pwm_h_next;
  logic   pwm_l_next;
  logic   active_next;
  logic   miss_next;

  // Kept apart from next-state decode so the counter's done never loops back into load.
  always_comb begin
    load_rise = 1'b0;
    load_fall = 1'b0;
    if (enable) begin
      case (state_reg)
        ST_OFF, ST_DT_FALL, ST_ON_L: load_rise = period_start;
        ST_DT_RISE:                  load_fall = duty_end;
        ST_ON_H:                     load_fall = duty_end & ~period_start;
        default:                     ;
      endcase
    end
  end

  assign dt_load = load_rise | load_fall;

  deadtime_counter #(
    .DT_W(DT_W)
  ) u_dt (
    .clk     (clk),
    .rst     (rst),
    .load    (dt_load),
    .load_val(dead_time),
    .done    (dt_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_OFF;
      pwm_h      <= 1'b0;
      pwm_l      <= 1'b0;
      active     <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pwm_h      <= pwm_h_next;
      pwm_l      <= pwm_l_next;
      active     <= active_next;
      miss_pulse <= miss_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (!enable) begin
      state_next = ST_OFF;
    end else if (load_rise) begin
      state_next = dt_done ? ST_ON_H : ST_DT_RISE;
    end else if (load_fall) begin
      state_next = dt_done ? ST_ON_L : ST_DT_FALL;
    end else if (state_reg == ST_DT_RISE && dt_done) begin
      state_next = ST_ON_H;
    end else if (state_reg == ST_DT_FALL && dt_done) begin
      state_next = ST_ON_L;
    end
  end

  // period_start while still high means the timer never ended the duty phase.
  always_comb begin
    pwm_h_next  = (state_next == ST_ON_H);
    pwm_l_next  = (state_next == ST_ON_L);
    active_next = (state_next != ST_OFF);
    miss_next   = enable & period_start & (state_reg == ST_ON_H);
  end

endmodule

// File: tb/tb_pwm_deadtime_driver.sv
// Directed and random stimulus for pwm_deadtime_driver with a queue of expected outputs.
module tb_pwm_deadtime_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       period_start = 1'b0;
  logic       duty_end = 1'b0;
  logic [3:0] dead_time = 4'd0;
  logic       pwm_h;
  logic       pwm_l;
  logic       active;
  logic       miss_pulse;

  typedef struct {
    logic [3:0] v;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic rnd_on = 1'b0;

  always #5 clk = ~clk;

  pwm_deadtime_driver #(
    .DT_W(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .period_start(period_start),
    .duty_end    (duty_end),
    .dead_time   (dead_time),
    .pwm_h       (pwm_h),
    .pwm_l       (pwm_l),
    .active      (active),
    .miss_pulse  (miss_pulse)
  );

  // Expected vector order: {pwm_h, pwm_l, active, miss_pulse}.
  always @(negedge clk) begin
    logic [3:0] obs;
    exp_t       e;
    obs = {pwm_h, pwm_l, active, miss_pulse};
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s observed %b expected %b", e.tag, obs, e.v);
      end
      $display("txn %-12s h_l_act_miss=%b expected=%b", e.tag, obs, e.v);
    end
    if (rnd_on) begin
      checks++;
      assert (!(pwm_h && pwm_l)) else begin
        errors++;
        $error("FAIL rnd_overlap observed h=%b l=%b expected not both 1", pwm_h, pwm_l);
      end
      checks++;
      assert (!(miss_pulse && !pwm_h)) else begin
        errors++;
        $error("FAIL rnd_miss observed miss=%b h=%b expected h=1 with miss", miss_pulse, pwm_h);
      end
    end
  end

  // One clock: drive inputs, queue the output expected after the edge.
  task automatic cyc(input logic r, input logic en, input logic ps, input logic de,
                     input logic [3:0] dt, input logic [3:0] ev, input string tag);
    exp_t e;
    rst          = r;
    enable       = en;
    period_start = ps;
    duty_end     = de;
    dead_time    = dt;
    e.v          = ev;
    e.tag        = tag;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic [3:0] dt, input logic [3:0] ev, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, dt, ev, tag);
  endtask

  initial begin
    // Reset, then dead_time 3: 3-cycle gaps on both edges.
    cyc(1, 1, 0, 0, 4'd3, 4'b0000, "rst0");
    cyc(1, 1, 0, 0, 4'd3, 4'b0000, "rst1");
    idle(7, 4'd3, 4'b0000, "t1_off");
    cyc(0, 1, 1, 0, 4'd3, 4'b0010, "t1_ps");
    idle(2, 4'd3, 4'b0010, "t1_dtr");
    idle(7, 4'd3, 4'b1010, "t1_onh");
    cyc(0, 1, 0, 1, 4'd3, 4'b0010, "t1_de");
    idle(2, 4'd3, 4'b0010, "t1_dtf");
    idle(3, 4'd3, 4'b0110, "t1_onl");

    // Zero dead time: direct swaps.
    cyc(0, 1, 1, 0, 4'd0, 4'b1010, "t2_ps");
    idle(3, 4'd0, 4'b1010, "t2_onh");
    cyc(0, 1, 0, 1, 4'd0, 4'b0110, "t2_de");
    idle(2, 4'd0, 4'b0110, "t2_onl");

    // Missed duty end, alone and coincident with duty_end.
    cyc(0, 1, 1, 0, 4'd0, 4'b1010, "t3_ps0");
    idle(2, 4'd0, 4'b1010, "t3_onh");
    cyc(0, 1, 1, 0, 4'd0, 4'b1011, "t3_miss");
    idle(2, 4'd0, 4'b1010, "t3_after");
    cyc(0, 1, 1, 1, 4'd0, 4'b1011, "t3_miss_de");
    idle(1, 4'd0, 4'b1010, "t3_after2");
    cyc(0, 1, 0, 1, 4'd0, 4'b0110, "t3_de");
    idle(1, 4'd0, 4'b0110, "t3_onl");

    // Duty end during the rising gap aborts it; pwm_h never rises.
    cyc(0, 1, 1, 0, 4'd5, 4'b0010, "t4_ps");
    idle(1, 4'd5, 4'b0010, "t4_dtr");
    cyc(0, 1, 0, 1, 4'd5, 4'b0010, "t4_de");
    idle(4, 4'd5, 4'b0010, "t4_dtf");
    idle(2, 4'd5, 4'b0110, "t4_onl");

    // Enable drop in ON_H, then reset in the middle of a falling gap.
    cyc(0, 1, 1, 0, 4'd0, 4'b1010, "t5_ps");
    idle(1, 4'd0, 4'b1010, "t5_onh");
    cyc(0, 0, 0, 0, 4'd0, 4'b0000, "t5_dis");
    cyc(0, 0, 1, 0, 4'd0, 4'b0000, "t5_dis_ps");
    cyc(0, 1, 1, 0, 4'd0, 4'b1010, "t5_ps2");
    cyc(0, 1, 0, 1, 4'd3, 4'b0010, "t5_de");
    idle(1, 4'd3, 4'b0010, "t5_dtf");
    cyc(1, 1, 0, 0, 4'd3, 4'b0000, "t5_rst");
    idle(2, 4'd3, 4'b0000, "t5_off");

    // dead_time change mid-gap only takes effect on the next entry.
    cyc(0, 1, 1, 0, 4'd2, 4'b0010, "t6_ps");
    cyc(0, 1, 0, 0, 4'd7, 4'b0010, "t6_dtr");
    cyc(0, 1, 0, 0, 4'd7, 4'b1010, "t6_onh");
    idle(1, 4'd7, 4'b1010, "t6_onh2");
    cyc(0, 1, 0, 1, 4'd7, 4'b0010, "t6_de");
    idle(6, 4'd7, 4'b0010, "t6_dtf");
    idle(1, 4'd7, 4'b0110, "t6_onl");

    // Maximum dead time.
    cyc(0, 1, 1, 0, 4'd15, 4'b0010, "t7_ps");
    idle(14, 4'd15, 4'b0010, "t7_dtr");
    idle(1, 4'd15, 4'b1010, "t7_onh");

    // Random traffic with the overlap invariant checked every cycle.
    rnd_on = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      rst          = 1'b0;
      enable       = ($urandom_range(0, 49) != 0);
      period_start = ($urandom_range(0, 7) == 0);
      duty_end     = ($urandom_range(0, 5) == 0);
      dead_time    = 4'($urandom_range(1, 15));
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    rnd_on = 1'b0;
    period_start = 1'b0;
    duty_end     = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
